// File: rtl/alu_result_stage.sv
// Result stage behind the ALU: two-entry skid buffer that captures each result
// with its N/Z/V/C flags and updates the architectural flag register on consume.
module alu_result_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic             in_set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       arch_flags,
    output logic [15:0]      pop_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] main_result_reg;
    logic [3:0]       main_flags_reg;
    logic             main_set_reg;
    logic [WIDTH-1:0] skid_result_reg;
    logic [3:0]       skid_flags_reg;
    logic             skid_set_reg;
    logic [3:0]       arch_flags_reg;
    logic [15:0]      pop_count_reg;

    logic             accept;
    logic             pop;
    logic             load_main;
    logic             load_skid;
    logic             shift_skid;
    logic [3:0]       in_flags;

    // Handshake outputs come from registered state only, so no combinational
    // path runs from in_valid/out_ready through this stage.
    assign in_ready  = (state_reg != TWO);
    assign out_valid = (state_reg != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // {N, Z, V, C} derived at capture time
    assign in_flags = {in_result[WIDTH-1], (in_result == '0), in_overflow, in_carry};

    always_comb begin
        state_next = state_reg;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        unique case (state_reg)
            EMPTY: begin
                if (accept) begin
                    load_main  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    shift_skid = 1'b1;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= EMPTY;
            main_result_reg <= '0;
            main_flags_reg  <= '0;
            main_set_reg    <= 1'b0;
            skid_result_reg <= '0;
            skid_flags_reg  <= '0;
            skid_set_reg    <= 1'b0;
            arch_flags_reg  <= '0;
            pop_count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (load_main) begin
                main_result_reg <= in_result;
                main_flags_reg  <= in_flags;
                main_set_reg    <= in_set_flags;
            end else if (shift_skid) begin
                main_result_reg <= skid_result_reg;
                main_flags_reg  <= skid_flags_reg;
                main_set_reg    <= skid_set_reg;
            end
            if (load_skid) begin
                skid_result_reg <= in_result;
                skid_flags_reg  <= in_flags;
                skid_set_reg    <= in_set_flags;
            end
            // The head entry is always main, so the popped entry's flags live there.
            if (pop) begin
                pop_count_reg <= pop_count_reg + 16'd1;
                if (main_set_reg) begin
                    arch_flags_reg <= main_flags_reg;
                end
            end
        end
    end

    assign out_result = main_result_reg;
    assign out_flags  = main_flags_reg;
    assign arch_flags = arch_flags_reg;
    assign pop_count  = pop_count_reg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_result;
    logic        in_carry;
    logic        in_overflow;
    logic        in_set_flags;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  arch_flags;
    logic [15:0] pop_count;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_carry    (in_carry),
        .in_overflow (in_overflow),
        .in_set_flags(in_set_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .arch_flags  (arch_flags),
        .pop_count   (pop_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [63:0] r;
        logic [3:0]  f;
        logic        s;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_arch = 4'd0;
    logic [15:0] m_pops = 16'd0;
    bit          m_acc;
    bit          m_pp;
    bit          chk_en  = 1'b0;
    bit          verbose = 1'b1;

    function automatic ent_t mk(logic [63:0] r, logic c, logic o, logic s);
        ent_t e;
        e.r = r;
        e.f = {r[63], (r == 64'd0), o, c};
        e.s = s;
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_arch = 4'd0;
            m_pops = 16'd0;
        end else begin
            m_acc = in_valid && (q.size() < 2);
            m_pp  = (q.size() > 0) && out_ready;
            if (m_pp) begin
                if (q[0].s) m_arch = q[0].f;
                m_pops = m_pops + 16'd1;
                if (verbose)
                    $display("pop #%0d result=%h flags=%b set=%0b", m_pops, q[0].r, q[0].f, q[0].s);
                void'(q.pop_front());
            end
            if (m_acc) q.push_back(mk(in_result, in_carry, in_overflow, in_set_flags));
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("cyc_out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("cyc_in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (q.size() > 0) begin
                check("cyc_out_result", out_result, q[0].r);
                check("cyc_out_flags", 64'(out_flags), 64'(q[0].f));
            end
            check("cyc_arch_flags", 64'(arch_flags), 64'(m_arch));
            check("cyc_pop_count", 64'(pop_count), 64'(m_pops));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [63:0] r, logic c, logic o, logic s);
        in_valid     = v;
        in_result    = r;
        in_carry     = c;
        in_overflow  = o;
        in_set_flags = s;
    endtask

    logic [63:0] a_val, b_val, c_val, prev_val, cur_val;
    int          guard;

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        check("rst_arch_flags", 64'(arch_flags), 64'd0);
        check("rst_pop_count", 64'(pop_count), 64'd0);
        chk_en = 1'b1;

        // Single pass with carry
        out_ready = 1'b1;
        drive(1'b1, 64'h5, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("single_out_valid", 64'(out_valid), 64'd1);
        check("single_out_result", out_result, 64'h5);
        check("single_out_flags", 64'(out_flags), 64'b0001);
        step();
        check("single_arch_flags", 64'(arch_flags), 64'b0001);
        check("single_pop_count", 64'(pop_count), 64'd1);

        // Zero then negative
        drive(1'b1, 64'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("zero_out_flags", 64'(out_flags), 64'b0100);
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        step();
        check("neg_arch_after_zero", 64'(arch_flags), 64'b0100);
        check("neg_out_flags", 64'(out_flags), 64'b1000);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("neg_arch_flags", 64'(arch_flags), 64'b1000);
        check("neg_pop_count", 64'(pop_count), 64'd3);

        // Backpressure with set_flags=0 entries: arch_flags must not move
        a_val = 64'h0000_0000_0000_00AA;
        b_val = 64'h0000_0000_0000_00BB;
        c_val = 64'h0000_0000_0000_00CC;
        out_ready = 1'b0;
        drive(1'b1, a_val, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, b_val, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_in_ready_two", 64'(in_ready), 64'd0);
        check("bp_head_a", out_result, a_val);
        drive(1'b1, c_val, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_in_ready_hold", 64'(in_ready), 64'd0);
        check("bp_head_a_stable", out_result, a_val);
        out_ready = 1'b1;
        step();
        check("bp_head_b", out_result, b_val);
        step();
        check("bp_head_c", out_result, c_val);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_pop_count", 64'(pop_count), 64'd6);
        check("bp_arch_unchanged", 64'(arch_flags), 64'b1000);
        check("bp_empty", 64'(out_valid), 64'd0);

        // Accept and pop together in ONE for 10 cycles
        prev_val = {$urandom, $urandom};
        drive(1'b1, prev_val, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            cur_val = {$urandom, $urandom};
            drive(1'b1, cur_val, 1'b0, 1'b0, 1'b0);
            step();
            check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_out_valid", 64'(out_valid), 64'd1);
            check("stream_out_result", out_result, cur_val);
            prev_val = cur_val;
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step();

        // Reset while holding two entries
        out_ready = 1'b0;
        drive(1'b1, 64'h8000_0000_0000_0001, 1'b1, 1'b1, 1'b1);
        step();
        step();
        check("rst2_in_ready_two", 64'(in_ready), 64'd0);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_in_ready", 64'(in_ready), 64'd1);
        check("rst2_arch_flags", 64'(arch_flags), 64'd0);
        check("rst2_pop_count", 64'(pop_count), 64'd0);

        // pop_count wrap: stream set_flags=0 entries until 0xFFFF pops
        verbose = 1'b0;
        drive(1'b1, 64'h1234, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_pops != 16'hFFFF && guard < 70000) begin
            step();
            guard++;
        end
        check("wrap_reached", 64'(guard < 70000), 64'd1);
        check("wrap_ffff", 64'(pop_count), 64'hFFFF);
        step();
        check("wrap_zero", 64'(pop_count), 64'h0000);
        check("wrap_arch_unchanged", 64'(arch_flags), 64'd0);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] r;
            int          sel;
            sel = int'($urandom_range(0, 7));
            r = {$urandom, $urandom};
            if (sel == 0) r = 64'd0;
            else if (sel == 1) r[63] = 1'b1;
            drive(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
